// File: rtl/aibcr3_rxdeser_pkg.sv
// Shared definitions for the AIB RX deserialiser.
//   state_t : FSM state encoding (IDLE / HUNT / LOCKED)
//   slip_w  : width of the slip/bit counters for a given deserialisation ratio
package aibcr3_rxdeser_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HUNT   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // $clog2(DES_W), never narrower than one bit.
    function automatic int slip_w(input int des_w);
        return (des_w > 2) ? $clog2(des_w) : 1;
    endfunction

endpackage

// File: rtl/aibcr3_rxdeser_sync.sv
// Two-flop capture of the RX pad bit on the forwarded clock.
// Ports:
//   i_clk  - forwarded RX clock
//   i_rstb - asynchronous active-low reset
//   i_d    - serial bit from the pad buffer
//   o_q    - captured bit, two cycles behind i_d
module aibcr3_rxdeser_sync (
    input  logic i_clk,
    input  logic i_rstb,
    input  logic i_d,
    output logic o_q
);

    logic r_s1;
    logic r_s2;

    always_ff @(posedge i_clk or negedge i_rstb) begin
        if (!i_rstb) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
        end
    end

    assign o_q = r_s2;

endmodule

// File: rtl/aibcr3_rxdeser.sv
// AIB RX deserialiser: captures the serial pad stream, word-aligns to a
// repeating training word using bit-slip, then emits DES_W-bit data words.
// Ports:
//   clk         - forwarded RX clock
//   rstb        - asynchronous active-low reset
//   rxpadin     - serial data from the RX pad buffer
//   rx_en       - receiver enable
//   por         - power-on-reset indication (synchronous disable)
//   rx_word     - deserialised word, bit 0 = earliest bit received
//   rx_word_vld - one-cycle pulse when rx_word updates
//   locked      - high while word alignment is established
//   slip_cnt    - cumulative bit-slips modulo DES_W
module aibcr3_rxdeser
    import aibcr3_rxdeser_pkg::*;
#(
    parameter int               DES_W     = 4,
    parameter logic [DES_W-1:0] TRAIN_PAT = DES_W'(1),
    parameter int               LOCK_CNT  = 4,
    localparam int              SW        = slip_w(DES_W)
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             rxpadin,
    input  logic             rx_en,
    input  logic             por,
    output logic [DES_W-1:0] rx_word,
    output logic             rx_word_vld,
    output logic             locked,
    output logic [SW-1:0]    slip_cnt
);

    state_t           r_state;
    state_t           w_nstate;
    logic [DES_W-1:0] r_sr;
    logic [DES_W-1:0] r_word;
    logic [SW-1:0]    r_bcnt;
    logic [SW-1:0]    r_slip;
    logic [3:0]       r_match;
    logic             r_hold;
    logic             r_vld;
    logic             w_gate;
    logic             w_s2;
    logic             w_bnd;
    logic             w_hit;
    logic [DES_W-1:0] w_frame;

    aibcr3_rxdeser_sync u_sync (
        .i_clk  (clk),
        .i_rstb (rstb),
        .i_d    (rxpadin),
        .o_q    (w_s2)
    );

    assign w_gate  = rx_en & ~por;
    // The frame is the shift register contents after this cycle's shift.
    assign w_frame = {w_s2, r_sr[DES_W-1:1]};
    assign w_bnd   = (r_state != IDLE) && (r_bcnt == SW'(DES_W - 1));
    assign w_hit   = (w_frame == TRAIN_PAT);

    always_comb begin
        w_nstate = r_state;
        if (!w_gate) begin
            w_nstate = IDLE;
        end else begin
            case (r_state)
                IDLE:    w_nstate = HUNT;
                HUNT:    if (w_bnd && w_hit && r_match == 4'(LOCK_CNT - 1))
                             w_nstate = LOCKED;
                default: w_nstate = r_state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state <= IDLE;
            r_sr    <= '0;
            r_word  <= '0;
            r_bcnt  <= '0;
            r_slip  <= '0;
            r_match <= '0;
            r_hold  <= 1'b0;
            r_vld   <= 1'b0;
        end else begin
            r_state <= w_nstate;
            r_vld   <= 1'b0;
            if (!w_gate || r_state == IDLE) begin
                // Disabled or just enabling: discard any partial frame.
                r_sr    <= '0;
                r_bcnt  <= '0;
                r_slip  <= '0;
                r_match <= '0;
                r_hold  <= 1'b0;
                if (!w_gate)
                    r_word <= '0;
            end else begin
                r_sr <= w_frame;
                // After a slip the counter stalls one cycle so the next
                // frame starts one bit later in the stream.
                if (r_hold)
                    r_hold <= 1'b0;
                else if (w_bnd)
                    r_bcnt <= '0;
                else
                    r_bcnt <= r_bcnt + SW'(1);
                if (w_bnd) begin
                    if (r_state == LOCKED) begin
                        r_word <= w_frame;
                        r_vld  <= 1'b1;
                    end else if (w_hit) begin
                        r_match <= r_match + 4'd1;
                    end else begin
                        r_match <= '0;
                        r_hold  <= 1'b1;
                        r_slip  <= (r_slip == SW'(DES_W - 1)) ? '0 : r_slip + SW'(1);
                    end
                end
            end
        end
    end

    assign rx_word     = r_word;
    assign rx_word_vld = r_vld;
    assign locked      = (r_state == LOCKED);
    assign slip_cnt    = r_slip;

endmodule

// File: doc/aibcr3_rxdeser.md
Name: aibcr3_rxdeser

Overview:
Receive-side digital companion to the AIB TX pad driver. It captures the single-bit stream arriving from the RX pad buffer on the forwarded clock and deserialises it into DES_W-bit words. It word-aligns to a repeating training pattern using bit-slip, then delivers data words with a valid pulse. It sits between the RX analog buffer and the adapter RX datapath.

Parameters:
DES_W, 4, deserialisation ratio; bits per word; allowed range 2..16.
TRAIN_PAT, 4'b0001, training word; must have DES_W distinct rotations. Bit 0 is the first bit received.
LOCK_CNT, 4, number of consecutive matching frames required to declare lock; range 1..15.

Ports:
clk  input  1  forwarded RX clock; rxpadin is synchronous to it.
rstb  input  1  asynchronous active-low reset.
rxpadin  input  1  serial data from the RX pad buffer.
rx_en  input  1  receiver enable; mirrors the TX-side itx_en_buf.
por  input  1  power-on-reset indication, active high. Treated as a synchronous disable.
rx_word  output  DES_W  deserialised word; bit 0 = earliest bit received.
rx_word_vld  output  1  one-cycle pulse when rx_word is updated.
locked  output  1  high while in LOCKED.
slip_cnt  output  $clog2(DES_W)  cumulative bit-slips, modulo DES_W.

Behaviour:
- Reset (rstb=0, asynchronous):
  - all flops cleared; state = IDLE.
  - rx_word = 0, rx_word_vld = 0, locked = 0, slip_cnt = 0.
- Enable: gate = rx_en & ~por, sampled every cycle.
- Input capture: rxpadin -> s1 -> s2 (two flops, reset to 0). s2 is the working bit.
- Shift register sr[DES_W-1:0] <= {s2, sr[DES_W-1:1]} every cycle while gate=1.
- Bit counter bcnt:
  - counts 0..DES_W-1 while gate=1.
  - A frame boundary occurs when bcnt == DES_W-1.
  - frame = {s2, sr[DES_W-1:1]}.
- States:
  - IDLE:
    - sr, bcnt, match_cnt, slip_cnt held at 0; outputs 0.
    - gate=1 -> HUNT on the next cycle.
  - HUNT, at each boundary:
    - frame == TRAIN_PAT: increment match_cnt. On reaching LOCK_CNT -> LOCKED; locked rises the cycle after the final matching boundary.
    - mismatch: match_cnt <= 0; slip_cnt <= slip_cnt+1, wrapping DES_W-1 -> 0. bcnt pauses for one cycle, so the next boundary comes DES_W+1 cycles later (one-bit shift).
    - Slips continue indefinitely; there is no timeout.
  - LOCKED, at each boundary:
    - rx_word <= frame and rx_word_vld = 1 for exactly one cycle, the cycle after the boundary.
    - No further pattern checking and no slips.
- gate=0 in any state -> IDLE on the next cycle:
  - locked, rx_word_vld, slip_cnt, match_cnt, sr, bcnt all clear.
  - rx_word also clears to 0.
  - A partially accumulated frame is discarded.
- Latency: the last bit of a word on rxpadin at cycle t gives rx_word/rx_word_vld at cycle t+3.
- In LOCKED, rx_word_vld is periodic with period DES_W and never back-to-back (DES_W ≥ 2).
- Simultaneous gate falling and a boundary: gate wins; no vld, no slip.
- A mid-operation rstb assertion clears everything immediately. Operation restarts in IDLE after release.

Decomposition:
- Shared package aibcr3_rxdeser_pkg:
  - state encodings IDLE=2'd0, HUNT=2'd1, LOCKED=2'd2.
  - function for the slip_cnt width.
- Sub-module aibcr3_rxdeser_sync: two-flop input capture (rxpadin -> s2) with async active-low reset, reusable for other RX lanes.
- The FSM, counters and shift register live in the top.

Test Plan:
1. Reset: drive rstb=0 while LOCKED and mid-frame -> locked, rx_word_vld, rx_word, slip_cnt read 0 in the same cycle. They stay 0 until rx_en returns and lock is re-acquired.
2. Aligned training (DES_W=4, TRAIN_PAT=0001, LOCK_CNT=4): rx_en=1, stream repeating 1,0,0,0 aligned to the first boundary -> slip_cnt=0 and locked rises after exactly 4 matching frames.
3. Misaligned training: stream offset by 2 bits (0,0,1,0 phase) -> exactly 2 mismatches, slip_cnt=2, then lock after 4 further matches. match_cnt reset is verified by inserting one bad frame after 3 matches.
4. Data after lock: send words 4'hA, 4'h5, 4'hF LSB-first -> rx_word = A, 5, F on pulses 4 cycles apart, each 3 cycles after its last bit.
5. Disable mid-lock: drop rx_en on a boundary cycle -> no vld pulse; state IDLE and locked=0 next cycle. Re-raising rx_en re-enters HUNT with slip_cnt=0.
6. POR gating: por=1 with rx_en=1 and the training pattern present -> state remains IDLE, no slips and no lock. Releasing por gives the same behaviour as scenario 2.
